// File: rtl/key_capture_pkg.sv
// Shared constants and helpers for the key capture front end.
// Feature macro: AUTOREPEAT_EN (held keys re-issue presses).
package key_capture_pkg;

  localparam int N_KEYS_DEF   = 8;
  localparam int DEBOUNCE_DEF = 16;
  localparam int REPEAT_DEF   = 1024;

  // Bits needed to count 0..v-1; never less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  localparam int DB_CNT_W  = clog2(DEBOUNCE_DEF);
  localparam int RPT_CNT_W = clog2(REPEAT_DEF);

endpackage

// File: rtl/key_debounce.sv
// Per-key synchroniser, debouncer and press pulse generator.
// Feature macro: AUTOREPEAT_EN adds a hold-repeat counter.
module key_debounce
  import key_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  localparam int DW = clog2(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_cfg
    $error("key_debounce: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_d;
  logic [DW-1:0] db_cnt;
  logic          rise;

  assign rise = stable & ~stable_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1    <= key;
      sync2    <= sync1;
      stable_d <= stable;
      if (sync2 == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int RW = clog2(REPEAT_CYCLES);

  logic [RW-1:0] rpt_cnt;
  logic          rpt;

  // Restart the period at every issued press so repeats are evenly spaced.
  assign rpt = stable & (rpt_cnt == RW'(REPEAT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt <= '0;
      press   <= 1'b0;
    end else begin
      if (!stable || rise || rpt)
        rpt_cnt <= '0;
      else
        rpt_cnt <= rpt_cnt + 1'b1;
      press <= rise | rpt;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) press <= 1'b0;
    else     press <= rise;
  end
`endif

endmodule

// File: rtl/key_onehot_capture.sv
// Debounced key presses queued and presented one-hot on valid/ready.
// Feature macro: AUTOREPEAT_EN (held keys re-issue presses).
module key_onehot_capture
  import key_capture_pkg::*;
#(
  parameter int N_KEYS          = N_KEYS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              overflow
);

  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] pending;
  logic [N_KEYS-1:0] pick;
  logic [N_KEYS-1:0] clr;
  logic              load;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .key   (key_in[g]),
      .press (press[g])
    );
  end

  // Lowest set bit wins: x & -x.
  assign pick = pending & (~pending + 1'b1);
  assign load = (!data_valid || data_ready) && (pending != '0);
  assign clr  = load ? pick : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      pending  <= (pending & ~clr) | press;
      overflow <= |(press & pending & ~clr);
      if (load) begin
        data_out   <= pick;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_out   <= '0;
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_onehot_capture.sv
// Directed bench for key_onehot_capture (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=32).
module tb_key_onehot_capture;

  logic       clk;
  logic       rst;
  logic [7:0] key_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       overflow;

  int n_cmp;
  int n_err;

  key_onehot_capture #(
    .N_KEYS          (8),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_CYCLES   (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    key_in = 8'h00;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    key_in = 8'hFF;
    data_ready = 1'b1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ({data_valid, overflow, data_out} !== 10'h000) begin
        n_err++;
        $display("FAIL reset_hold k=%0d: got v=%b o=%b d=%h want 0/0/00",
                 k, data_valid, overflow, data_out);
      end
    end
    key_in = 8'h00;
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_cmp++;
      if (data_valid !== 1'b0 || overflow !== 1'b0) begin
        n_err++;
        $display("FAIL reset_quiet k=%0d: got v=%b o=%b want 0/0",
                 k, data_valid, overflow);
      end
    end
  endtask

  task automatic test_single_press;
    logic [7:0] exp_d;
    do_reset();
    data_ready = 1'b1;
    key_in = 8'h04;
    for (int k = 0; k < 20; k++) begin
      tick();
      exp_d = (k == 8) ? 8'h04 : 8'h00;
      n_cmp++;
      if (data_valid !== (k == 8) || data_out !== exp_d || overflow !== 1'b0) begin
        n_err++;
        $display("FAIL single_press edge=%0d: got v=%b d=%h o=%b want v=%b d=%h o=0",
                 k, data_valid, data_out, overflow, (k == 8), exp_d);
      end
    end
    key_in = 8'h00;
    for (int k = 0; k < 10; k++) tick();
  endtask

  task automatic test_glitch;
    int nv;
    do_reset();
    data_ready = 1'b1;
    nv = 0;
    key_in = 8'h01;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (k == 2) key_in = 8'h00;
      if (data_valid) nv++;
    end
    n_cmp++;
    if (nv != 0) begin
      n_err++;
      $display("FAIL glitch: got %0d valid cycles want 0", nv);
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    data_ready = 1'b0;
    key_in = 8'h48;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (k == 9) key_in = 8'h00;
      if (k >= 8) begin
        n_cmp++;
        if (data_valid !== 1'b1 || data_out !== 8'h08) begin
          n_err++;
          $display("FAIL bp_hold edge=%0d: got v=%b d=%h want 1/08",
                   k, data_valid, data_out);
        end
      end
    end
    data_ready = 1'b1;
    #1;
    n_cmp++;
    if (data_valid !== 1'b1 || data_out !== 8'h08) begin
      n_err++;
      $display("FAIL bp_first: got v=%b d=%h want 1/08", data_valid, data_out);
    end
    tick();
    n_cmp++;
    if (data_valid !== 1'b1 || data_out !== 8'h40) begin
      n_err++;
      $display("FAIL bp_second: got v=%b d=%h want 1/40", data_valid, data_out);
    end
    tick();
    n_cmp++;
    if (data_valid !== 1'b0 || data_out !== 8'h00) begin
      n_err++;
      $display("FAIL bp_drain: got v=%b d=%h want 0/00", data_valid, data_out);
    end
  endtask

  task automatic test_overflow;
    int n_ovf;
    int n_04;
    int n_val;
    int n_bad;
    do_reset();
    data_ready = 1'b0;
    key_in = 8'h06;
    for (int k = 0; k < 10; k++) tick();
    key_in = 8'h00;
    n_ovf = 0;
    n_bad = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (overflow) n_ovf++;
    end
    key_in = 8'h04;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (overflow) n_ovf++;
      if (data_valid !== 1'b1 || data_out !== 8'h02) n_bad++;
    end
    key_in = 8'h00;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (overflow) n_ovf++;
    end
    n_cmp++;
    if (n_ovf != 1) begin
      n_err++;
      $display("FAIL ovf_pulse: got %0d overflow cycles want 1", n_ovf);
    end
    n_cmp++;
    if (n_bad != 0) begin
      n_err++;
      $display("FAIL ovf_stall: got %0d unstable cycles want 0", n_bad);
    end
    data_ready = 1'b1;
    tick();
    n_cmp++;
    if (data_valid !== 1'b1 || data_out !== 8'h04) begin
      n_err++;
      $display("FAIL ovf_next: got v=%b d=%h want 1/04", data_valid, data_out);
    end
    n_04 = 1;
    n_val = 1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (data_valid) n_val++;
      if (data_valid && data_out == 8'h04) n_04++;
    end
    n_cmp++;
    if (n_04 != 1 || n_val != 1) begin
      n_err++;
      $display("FAIL ovf_once: got %0d x 04, %0d valid want 1/1", n_04, n_val);
    end
  endtask

  task automatic test_reset_midflight;
    int nv;
    do_reset();
    data_ready = 1'b0;
    key_in = 8'h31;
    for (int k = 0; k < 10; k++) tick();
    key_in = 8'h00;
    for (int k = 0; k < 12; k++) tick();
    n_cmp++;
    if (data_valid !== 1'b1 || data_out !== 8'h01) begin
      n_err++;
      $display("FAIL rstmid_pre: got v=%b d=%h want 1/01", data_valid, data_out);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (data_valid !== 1'b0 || data_out !== 8'h00) begin
      n_err++;
      $display("FAIL rstmid_post: got v=%b d=%h want 0/00", data_valid, data_out);
    end
    data_ready = 1'b1;
    nv = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (data_valid) nv++;
    end
    n_cmp++;
    if (nv != 0) begin
      n_err++;
      $display("FAIL rstmid_stale: got %0d valid cycles want 0", nv);
    end
  endtask

  task automatic test_autorepeat;
    int n_80;
    int first;
    int exp_n;
    do_reset();
    data_ready = 1'b1;
    n_80 = 0;
    first = -1;
`ifdef AUTOREPEAT_EN
    exp_n = 4;
`else
    exp_n = 1;
`endif
    key_in = 8'h80;
    for (int k = 0; k < 150; k++) begin
      tick();
      if (k == 99) key_in = 8'h00;
      if (data_valid && data_out == 8'h80) begin
        n_80++;
        if (first < 0) first = k;
      end
    end
    n_cmp++;
    if (n_80 != exp_n) begin
      n_err++;
      $display("FAIL repeat_count: got %0d deliveries want %0d", n_80, exp_n);
    end
    n_cmp++;
    if (first != 8) begin
      n_err++;
      $display("FAIL repeat_first: got edge %0d want 8", first);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    key_in = 8'h00;
    data_ready = 1'b1;
    test_reset();
    test_single_press();
    test_glitch();
    test_backpressure();
    test_overflow();
    test_reset_midflight();
    test_autorepeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
